// File: rtl/matmul_sequencer.sv
// Controller for the matrix-multiplier datapath: loads the column RAMs from the M FIFO,
// streams hash words through the PE array, drains the PE pipeline and emits result words.
module matmul_sequencer #(
    parameter int unsigned N_COLS     = 64,
    parameter int unsigned N_ROWS     = 64,
    parameter int unsigned HASH_WORDS = 64,
    parameter int unsigned OUT_WORDS  = 4,
    parameter int unsigned PE_LAT     = 2,
    parameter int unsigned AW         = $clog2(N_ROWS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_empty,
    input  logic                         hashin_empty,
    input  logic                         hashout_full,
    output logic                         m_re,
    output logic                         ram_we,
    output logic [AW-1:0]                ram_addr,
    output logic [N_COLS-1:0]            en_column,
    output logic                         addr_sel,
    output logic                         hashin_re,
    output logic                         pe_en,
    output logic                         pe_clr,
    output logic                         hashout_we,
    output logic [$clog2(OUT_WORDS):0]   out_idx,
    output logic                         busy,
    output logic                         matrix_loaded,
    output logic [31:0]                  hash_count
);

    localparam int unsigned KW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int unsigned DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam int unsigned OW = $clog2(OUT_WORDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      i_q, i_d;
    logic [KW-1:0]      k_q, k_d;
    logic [AW-1:0]      j_q, j_d;
    logic [DW-1:0]      d_q, d_d;
    logic [OW-1:0]      t_q, t_d;
    logic               loaded_q, loaded_d;
    logic [31:0]        hash_count_q, hash_count_d;
    logic [PE_LAT-1:0]  pe_pipe_q, pe_pipe_d;

    // Next-state, counter updates and the combinational FIFO/RAM strobes
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        k_d          = k_q;
        j_d          = j_q;
        d_d          = d_q;
        t_d          = t_q;
        loaded_d     = loaded_q;
        hash_count_d = hash_count_q;
        m_re         = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        en_column    = '0;
        addr_sel     = 1'b1;
        hashin_re    = 1'b0;
        pe_clr       = 1'b0;
        hashout_we   = 1'b0;
        out_idx      = '0;

        case (state_q)
            S_IDLE: begin
                // A pending matrix update always wins over a pending hash
                if (!m_empty) begin
                    state_d  = S_LOAD;
                    loaded_d = 1'b0;
                    i_d      = '0;
                    k_d      = '0;
                end else if (loaded_q && !hashin_empty) begin
                    state_d = S_MULT;
                    pe_clr  = 1'b1;
                    j_d     = '0;
                end
            end
            S_LOAD: begin
                addr_sel = 1'b0;
                ram_addr = i_q;
                if (!m_empty) begin
                    m_re      = 1'b1;
                    ram_we    = 1'b1;
                    en_column = N_COLS'(1) << k_q;
                    if (i_q == AW'(N_ROWS - 1)) begin
                        i_d = '0;
                        if (k_q == KW'(N_COLS - 1)) begin
                            k_d      = '0;
                            loaded_d = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end else begin
                        i_d = i_q + AW'(1);
                    end
                end
            end
            S_MULT: begin
                ram_addr = j_q;
                if (!hashin_empty) begin
                    hashin_re = 1'b1;
                    en_column = '1;
                    if (j_q == AW'(HASH_WORDS - 1)) begin
                        j_d     = '0;
                        d_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        j_d = j_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (d_q == DW'(PE_LAT - 1)) begin
                    d_d     = '0;
                    t_d     = '0;
                    state_d = S_OUT;
                end else begin
                    d_d = d_q + DW'(1);
                end
            end
            S_OUT: begin
                if (!hashout_full) begin
                    hashout_we = 1'b1;
                    out_idx    = t_q;
                    if (t_q == OW'(OUT_WORDS - 1)) begin
                        t_d          = '0;
                        hash_count_d = hash_count_q + 32'd1;
                        state_d      = S_IDLE;
                    end else begin
                        t_d = t_q + OW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PE operand-valid chain: hashin_re delayed by PE_LAT cycles, bubbles included
    always_comb begin
        pe_pipe_d    = pe_pipe_q;
        pe_pipe_d[0] = hashin_re;
        for (int s = 1; s < int'(PE_LAT); s++) begin
            pe_pipe_d[s] = pe_pipe_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            k_q          <= '0;
            j_q          <= '0;
            d_q          <= '0;
            t_q          <= '0;
            loaded_q     <= 1'b0;
            hash_count_q <= '0;
            pe_pipe_q    <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            k_q          <= k_d;
            j_q          <= j_d;
            d_q          <= d_d;
            t_q          <= t_d;
            loaded_q     <= loaded_d;
            hash_count_q <= hash_count_d;
            pe_pipe_q    <= pe_pipe_d;
        end
    end

    assign pe_en         = pe_pipe_q[PE_LAT-1];
    assign busy          = (state_q != S_IDLE);
    assign matrix_loaded = loaded_q;
    assign hash_count    = hash_count_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: directed scenarios plus random FIFO-flag traffic, checked
// every cycle against a transaction-level model of loads, hash passes and result writes.
module tb_matmul_sequencer;

    localparam int unsigned NC    = 4;
    localparam int unsigned NR    = 4;
    localparam int unsigned HW    = 4;
    localparam int unsigned OWD   = 2;
    localparam int unsigned PL    = 2;
    localparam int unsigned TOTAL = NC * NR;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_empty, hashin_empty, hashout_full;
    logic        m_re, ram_we, addr_sel, hashin_re, pe_en, pe_clr, hashout_we;
    logic        busy, matrix_loaded;
    logic [1:0]  ram_addr;
    logic [3:0]  en_column;
    logic [1:0]  out_idx;
    logic [31:0] hash_count;

    matmul_sequencer #(
        .N_COLS(NC), .N_ROWS(NR), .HASH_WORDS(HW), .OUT_WORDS(OWD), .PE_LAT(PL)
    ) dut (
        .clk(clk), .rst(rst),
        .m_empty(m_empty), .hashin_empty(hashin_empty), .hashout_full(hashout_full),
        .m_re(m_re), .ram_we(ram_we), .ram_addr(ram_addr), .en_column(en_column),
        .addr_sel(addr_sel), .hashin_re(hashin_re), .pe_en(pe_en), .pe_clr(pe_clr),
        .hashout_we(hashout_we), .out_idx(out_idx), .busy(busy),
        .matrix_loaded(matrix_loaded), .hash_count(hash_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: pending work expressed as remaining transfers
    bit          ld_act, rd_act, wr_act, mdl_loaded;
    int          ld_pos, rd_pos, wr_pos, wait_left;
    logic [31:0] mdl_count;
    bit          hist[PL];

    int cyc = 0;
    int n_mre, n_hre, n_hwe, n_pe, n_clr;
    int acc_cyc = 0;
    int lat = -1;

    task automatic model_reset();
        ld_act = 0; rd_act = 0; wr_act = 0; mdl_loaded = 0;
        ld_pos = 0; rd_pos = 0; wr_pos = 0; wait_left = 0;
        mdl_count = '0;
        for (int s = 0; s < int'(PL); s++) hist[s] = 0;
    endtask

    task automatic clear_tallies();
        n_mre = 0; n_hre = 0; n_hwe = 0; n_pe = 0; n_clr = 0;
    endtask

    function automatic logic [63:0] raw_outs();
        return 64'({m_re, ram_we, ram_addr, en_column, addr_sel, hashin_re, pe_en, pe_clr,
                    hashout_we, out_idx, busy, matrix_loaded, hash_count});
    endfunction

    localparam logic [63:0] IDLE_RESET_OUTS =
        64'({1'b0, 1'b0, 2'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b0, 1'b0, 1'b0, 32'd0});

    // One clock: drive flags, compare at negedge against the model, then advance the model
    task automatic cycle(input bit me, input bit he, input bit hf, input bit r);
        bit          e_mre, e_we, e_sel, e_hre, e_clr, e_hwe, e_busy, e_ld, e_pe;
        logic [1:0]  e_addr, e_idx;
        logic [3:0]  e_en;
        logic [31:0] e_cnt;
        logic [63:0] got, exp;
        m_empty = me; hashin_empty = he; hashout_full = hf; rst = r;
        @(negedge clk);
        e_mre = 0; e_we = 0; e_sel = 1; e_hre = 0; e_clr = 0; e_hwe = 0;
        e_addr = '0; e_idx = '0; e_en = '0;
        e_busy = ld_act || rd_act || (wait_left > 0) || wr_act;
        e_ld   = mdl_loaded;
        e_cnt  = mdl_count;
        e_pe   = hist[PL-1];
        if (ld_act) begin
            e_sel = 0;
            if (!me) begin
                e_mre = 1; e_we = 1;
                e_addr = 2'(ld_pos % NR);
                e_en   = 4'(1) << (ld_pos / NR);
                if (ld_pos == int'(TOTAL) - 1) begin
                    ld_act = 0; mdl_loaded = 1;
                end
                ld_pos++;
            end
        end else if (rd_act) begin
            if (!he) begin
                e_hre = 1; e_addr = 2'(rd_pos); e_en = 4'hf;
                if (rd_pos == int'(HW) - 1) begin
                    rd_act = 0; wait_left = PL;
                end
                rd_pos++;
            end
        end else if (wait_left > 0) begin
            wait_left--;
            if (wait_left == 0) begin
                wr_act = 1; wr_pos = 0;
            end
        end else if (wr_act) begin
            if (!hf) begin
                e_hwe = 1; e_idx = 2'(wr_pos);
                if (wr_pos == int'(OWD) - 1) begin
                    wr_act = 0; mdl_count = mdl_count + 32'd1;
                end
                wr_pos++;
            end
        end else if (!me) begin
            ld_act = 1; ld_pos = 0; mdl_loaded = 0;
        end else if (mdl_loaded && !he) begin
            e_clr = 1; rd_act = 1; rd_pos = 0;
        end
        for (int s = int'(PL) - 1; s > 0; s--) hist[s] = hist[s-1];
        hist[0] = e_hre;
        if (r) model_reset();

        got = 64'({m_re, ram_we, (ram_we || hashin_re) ? ram_addr : 2'b0, en_column, addr_sel,
                   hashin_re, pe_en, pe_clr, hashout_we, hashout_we ? out_idx : 2'b0,
                   busy, matrix_loaded, hash_count});
        exp = 64'({e_mre, e_we, e_addr, e_en, e_sel, e_hre, e_pe, e_clr, e_hwe, e_idx,
                   e_busy, e_ld, e_cnt});
        check_eq($sformatf("cyc%0d", cyc), got, exp);

        if (m_re) n_mre++;
        if (hashin_re) n_hre++;
        if (hashout_we) n_hwe++;
        if (pe_en) n_pe++;
        if (pe_clr) begin
            n_clr++;
            acc_cyc = cyc;
        end
        if (hashout_we && lat < 0) lat = cyc - acc_cyc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; m_empty = 1'b1; hashin_empty = 1'b1; hashout_full = 1'b0;
        model_reset();
        clear_tallies();
        @(posedge clk);
        #1;
        check_eq("reset_outs", raw_outs(), IDLE_RESET_OUTS);

        // Full load from reset
        repeat (17) cycle(0, 1, 0, 0);
        check_eq("load_mre_cnt", 64'(n_mre), 64'd16);
        check_eq("load_done", 64'({matrix_loaded, busy}), 64'b10);
        cycle(1, 1, 0, 0);

        // Hash waiting without a matrix, then load and accept
        cycle(1, 1, 0, 1);
        clear_tallies();
        repeat (20) cycle(1, 0, 0, 0);
        check_eq("noload_hre", 64'(n_hre), 64'd0);
        check_eq("noload_busy", 64'(busy), 64'd0);
        lat = -1;
        repeat (17) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check_eq("accept_clr", 64'(n_clr), 64'd1);

        // Clean pass following that accept
        clear_tallies();
        repeat (4) cycle(1, 0, 0, 0);
        repeat (4) cycle(1, 1, 0, 0);
        check_eq("clean_reads", 64'(n_hre), 64'd4);
        check_eq("clean_pe", 64'(n_pe), 64'd4);
        check_eq("clean_writes", 64'(n_hwe), 64'd2);
        check_eq("clean_latency", 64'(lat), 64'(HW + PL + 1));
        check_eq("clean_count", 64'(hash_count), 64'd1);

        // Hashin stall after word 1, hashout full for 3 cycles
        clear_tallies();
        cycle(1, 0, 0, 0);
        repeat (2) cycle(1, 0, 0, 0);
        repeat (2) cycle(1, 1, 0, 0);
        repeat (2) cycle(1, 0, 0, 0);
        repeat (2) cycle(1, 1, 0, 0);
        repeat (3) cycle(1, 1, 1, 0);
        repeat (3) cycle(1, 1, 0, 0);
        check_eq("stall_reads", 64'(n_hre), 64'd4);
        check_eq("stall_writes", 64'(n_hwe), 64'd2);
        check_eq("stall_count", 64'(hash_count), 64'd2);

        // Reload wins over pending hash
        cycle(0, 0, 0, 0);
        check_eq("reload_unloaded", 64'({matrix_loaded, busy}), 64'b01);
        repeat (16) cycle(0, 0, 0, 0);
        repeat (5) cycle(1, 0, 0, 0);
        repeat (5) cycle(1, 1, 0, 0);
        check_eq("reload_count", 64'(hash_count), 64'd3);

        // Reset in the middle of a load
        cycle(0, 1, 0, 0);
        repeat (9) cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 1);
        m_empty = 1'b1;
        #1;
        check_eq("midload_reset", raw_outs(), IDLE_RESET_OUTS);
        repeat (17) cycle(0, 1, 0, 0);
        check_eq("reload_after_rst", 64'(matrix_loaded), 64'd1);

        // Random flag traffic
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 399) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
